// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit producing HI/LO for MULT, MULTU, DIV, DIVU.
//   One operand bit is processed per cycle (shift/add multiply, restoring divide),
//   followed by a sign-fixup cycle. Results land in hi/lo with a one-cycle done
//   pulse that serves as the special-register write strobe.
//
// Ports
//   clk, reset        : system clock, synchronous active-high reset
//   start             : request a new operation (taken only in IDLE or DONE)
//   divide            : 0 = multiply, 1 = divide
//   unsignedOp        : 1 = unsigned operation
//   srcA, srcB        : rs / rt operands
//   readHiLo          : current instruction is MFHI/MFLO
//   busy              : operation in flight (MUL, DIV, FIXUP)
//   stall             : freeze PC/instruction while busy and a dependent access arrives
//   done              : one-cycle pulse, hi/lo valid with new result
//   hi, lo            : result registers
//
// state  | meaning
// IDLE   | waiting for start
// MUL    | shift/add iterations, multiplier LSB first
// DIV    | restoring-divide iterations
// FIXUP  | sign correction, hi/lo written at the end of this cycle
// DONE   | done pulse; a new start may be accepted here

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             divide,
  input  logic             unsignedOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             readHiLo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;     // {upper/remainder, multiplier/dividend->quotient}
  logic [WIDTH-1:0]   opb;     // multiplicand or divisor magnitude
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_lo;  // product or quotient negative
  logic               neg_hi;  // remainder negative

  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign a_neg    = ~unsignedOp & srcA[WIDTH-1];
  assign b_neg    = ~unsignedOp & srcB[WIDTH-1];
  assign mag_a    = a_neg ? (~srcA + 1'b1) : srcA;
  assign mag_b    = b_neg ? (~srcB + 1'b1) : srcB;
  assign div_zero = (srcB == '0);

  // Multiply step: conditional add into the upper half, then shift right with carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: remainder after the left shift is WIDTH+1 bits; the trial
  // subtraction's top bit is its sign because rem_sh < 2*divisor.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic               trial_ok;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh   = {acc[2*WIDTH-1:WIDTH-1]};
  assign trial    = rem_sh - {1'b0, opb};
  assign trial_ok = ~trial[WIDTH];
  assign div_next = {(trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                     acc[WIDTH-2:0], trial_ok};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_lo ? (~acc + 1'b1) : acc;
  assign quo_fix  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  assign stall = busy & (readHiLo | start);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      opb    <= '0;
      count  <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count  <= '0;
            busy   <= 1'b1;
            is_div <= divide;
            if (divide) begin
              // Divide by zero keeps the raw dividend so it falls out as the
              // remainder, with all-ones quotient and no sign correction.
              acc    <= {{WIDTH{1'b0}}, (div_zero ? srcA : mag_a)};
              opb    <= mag_b;
              neg_lo <= ~div_zero & (a_neg ^ b_neg);
              neg_hi <= ~div_zero & a_neg;
              state  <= DIV;
            end else begin
              acc    <= {{WIDTH{1'b0}}, mag_b};
              opb    <= mag_a;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= 1'b0;
              state  <= MUL;
            end
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          acc   <= mul_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) state <= FIXUP;
        end
        DIV: begin
          acc   <= div_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          reset, start, divide, unsignedOp, readHiLo;
  logic [W-1:0]  srcA, srcB;
  logic          busy, stall, done;
  logic [W-1:0]  hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .divide(divide),
    .unsignedOp(unsignedOp), .srcA(srcA), .srcB(srcB), .readHiLo(readHiLo),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, signed division truncates toward zero.
  task automatic model(input bit dv, input bit uns, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!dv) begin
      if (uns) p = {32'b0, a} * {32'b0, b};
      else     p = 64'(sa * sb);
      ehi = p[63:32];
      elo = p[31:0];
    end else if (b == 0) begin
      ehi = a;
      elo = '1;
    end else if (uns) begin
      elo = a / b;
      ehi = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
      elo = q[31:0];
      ehi = r[31:0];
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // From the cycle after acceptance, wait for done. Returns latency in cycles
  // from the accepting cycle; raises readHiLo from cycle rd_from (0 = never).
  task automatic wait_done(input int rd_from, output int lat, output int busy_cnt,
                           output int stall_cnt);
    lat = 0; busy_cnt = 0; stall_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (rd_from != 0 && k == rd_from) readHiLo = 1'b1;
      #1;
      if (busy)  busy_cnt++;
      if (stall) stall_cnt++;
      if (done) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic drive(input bit dv, input bit uns, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; divide = dv; unsignedOp = uns; srcA = a; srcB = b;
  endtask

  task automatic run_op(input string tag, input bit dv, input bit uns,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ehi, elo;
    int lat, bc, sc;
    model(dv, uns, a, b, ehi, elo);
    drive(dv, uns, a, b);
    tick();
    start = 1'b0;
    srcA = $urandom; srcB = $urandom; divide = $urandom_range(0, 1);
    wait_done(0, lat, bc, sc);
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " busy_cycles"}, 64'(bc), 64'(LAT - 1));
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
    tick();
    check({tag, " done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ehi, elo, ehi2, elo2;
    int lat, bc, sc, dcount;

    reset = 1'b1; start = 1'b0; divide = 1'b0; unsignedOp = 1'b0;
    srcA = '0; srcB = '0; readHiLo = 1'b0;
    tick(); tick();
    reset = 1'b0;
    readHiLo = 1'b1;
    #1;
    check("reset busy",  64'(busy),  64'(0));
    check("reset done",  64'(done),  64'(0));
    check("reset stall", 64'(stall), 64'(0));
    check("reset hi",    64'(hi),    64'(0));
    check("reset lo",    64'(lo),    64'(0));
    readHiLo = 1'b0;

    // Directed plan items
    run_op("mult_7_m3", 0, 0, 32'd7, 32'hFFFF_FFFD);
    check("mult_7_m3 hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_7_m3 lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    run_op("multu_ff", 0, 1, '1, '1);
    check("multu_ff hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_ff lo_const", 64'(lo), 64'h0000_0000_0000_0001);
    run_op("mult_ff", 0, 0, '1, '1);
    check("mult_ff hi_const", 64'(hi), 64'h0);
    check("mult_ff lo_const", 64'(lo), 64'h1);
    run_op("div_m7_2", 1, 0, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2 lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_m7_2 hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    run_op("div0", 1, 1, 32'h64, 32'h0);
    check("div0 lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    check("div0 hi_const", 64'(hi), 64'h64);
    run_op("div0_signed_neg", 1, 0, 32'hFFFF_FF00, 32'h0);
    run_op("div_ovf", 1, 0, 32'h8000_0000, '1);
    check("div_ovf lo_const", 64'(lo), 64'h8000_0000);
    check("div_ovf hi_const", 64'(hi), 64'h0);
    run_op("mult_by0", 0, 0, 32'h1234_5678, 32'h0);
    run_op("mult_by1", 0, 1, 32'hDEAD_BEEF, 32'h1);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pick(), pick());
    end

    // MFHI/MFLO hazard: readHiLo raised at N+5 stalls through N+33.
    model(0, 0, 32'd123, 32'hFFFF_FF00, ehi, elo);
    drive(0, 0, 32'd123, 32'hFFFF_FF00);
    tick();
    start = 1'b0;
    wait_done(5, lat, bc, sc);
    check("rd_haz latency", 64'(lat), 64'(LAT));
    check("rd_haz stall_cycles", 64'(sc), 64'(LAT - 1 - 4));
    check("rd_haz stall_at_done", 64'(stall), 64'(0));
    check("rd_haz lo", 64'(lo), 64'(elo));
    check("rd_haz hi", 64'(hi), 64'(ehi));
    readHiLo = 1'b0;
    tick();

    // Back-to-back: second start held during busy, accepted in the DONE cycle.
    model(1, 1, 32'd100, 32'd7, ehi, elo);
    model(0, 1, 32'hFFFF_0000, 32'd3, ehi2, elo2);
    drive(1, 1, 32'd100, 32'd7);
    tick();
    drive(0, 1, 32'hFFFF_0000, 32'd3);
    wait_done(0, lat, bc, sc);
    check("b2b op1 latency", 64'(lat), 64'(LAT));
    check("b2b op1 stall_cycles", 64'(sc), 64'(LAT - 1));
    check("b2b op1 stall_at_done", 64'(stall), 64'(0));
    check("b2b op1 lo", 64'(lo), 64'(elo));
    check("b2b op1 hi", 64'(hi), 64'(ehi));
    tick();
    start = 1'b0;
    wait_done(0, lat, bc, sc);
    check("b2b op2 latency", 64'(lat), 64'(LAT));
    check("b2b op2 hi", 64'(hi), 64'(ehi2));
    check("b2b op2 lo", 64'(lo), 64'(elo2));
    tick();

    // Establish known hi/lo, then reset mid-operation at N+10.
    run_op("divu_100_7", 1, 1, 32'd100, 32'd7);
    drive(0, 0, 32'd3, 32'd5);
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    check("pre_reset lo_hold", 64'(lo), 64'd14);
    check("pre_reset busy", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    readHiLo = 1'b1;
    #1;
    check("midrst busy",  64'(busy),  64'(0));
    check("midrst stall", 64'(stall), 64'(0));
    check("midrst done",  64'(done),  64'(0));
    check("midrst hi",    64'(hi),    64'(0));
    check("midrst lo",    64'(lo),    64'(0));
    readHiLo = 1'b0;
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dcount++;
      tick();
    end
    check("midrst no_done", 64'(dcount), 64'(0));
    run_op("post_reset", 0, 0, 32'hFFFF_FFF0, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multicycle multiply/divide unit that computes the HI/LO results for MULT, MULTU, DIV and DIVU.
It sits beside the single-cycle ALU and drives the special-register file write port (hi, lo, done).
It asserts a stall to the PC/instruction path while an operation is in flight and a dependent access arrives.
It replaces the single-cycle multiply and divide ALU paths with a 32-iteration shift/add and restoring-divide sequence.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when the unit can accept
divide  input  1  0 = multiply, 1 = divide; sampled with start
unsignedOp  input  1  1 = MULTU/DIVU, 0 = signed; sampled with start
srcA  input  WIDTH  rs operand: multiplicand or dividend
srcB  input  WIDTH  rt operand: multiplier or divisor
readHiLo  input  1  the current instruction is MFHI/MFLO
busy  output  1  an operation is in progress
stall  output  1  freeze the PC and the instruction
done  output  1  one-cycle pulse; hi/lo updated this cycle, used as the spregfile write strobe
hi  output  WIDTH  HI result: upper product or remainder
lo  output  WIDTH  LO result: lower product or quotient

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; busy = 0, done = 0, stall = 0; hi = lo = 0.
  - Iteration counter and working registers are cleared.
  - Reset asserted mid-operation aborts the operation: no done pulse, and hi/lo read 0 on the next cycle.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Accepting a request:
  - Accepted when start = 1 in IDLE or DONE; call this cycle N.
  - Latched at acceptance: divide, unsignedOp, and operand magnitudes. Signed operands are absolute-valued.
  - Result signs are recorded: product/quotient negative = sign(A) XOR sign(B); remainder negative = sign(A).
  - Both signs are forced positive when unsignedOp = 1.
  - Counter is set to 0; next state is MUL or DIV.
- MUL (cycles N+1 .. N+WIDTH), one multiplier bit per cycle, LSB first:
  - If the current bit is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator with carry.
  - Then shift the accumulator right by 1.
  - Counter increments; at counter = WIDTH-1 go to FIXUP.
- DIV (cycles N+1 .. N+WIDTH), restoring algorithm:
  - Shift {remainder, dividend} left by 1.
  - Trial remainder = remainder - divisor, computed WIDTH+1 bits wide.
  - If non-negative, keep the trial value and set the quotient bit to 1; otherwise restore and set it to 0.
  - Counter increments; at counter = WIDTH-1 go to FIXUP.
- FIXUP (cycle N+WIDTH+1):
  - Apply sign correction by two's-complement negation: the full 2*WIDTH product, the quotient, and the remainder, each per its recorded sign.
  - Results are written to hi/lo on the clock edge ending this cycle.
- DONE (cycle N+WIDTH+2):
  - done = 1 and hi/lo hold the new values.
  - Next state is IDLE, or MUL/DIV if a new start is accepted this cycle.
- Timing summary:
  - busy = 1 exactly in MUL, DIV and FIXUP, i.e. cycles N+1 .. N+WIDTH+1.
  - Latency from start to done is WIDTH+2 cycles (34 at default).
- Stall:
  - stall = busy AND (readHiLo OR start), combinational.
  - A start or MFHI/MFLO arriving while busy is held and never dropped.
  - A start arriving while busy is ignored internally and re-presented by the held pipeline; it is accepted in the DONE cycle.
  - readHiLo in the DONE cycle does not stall and reads the new hi/lo.
- Divide by zero (srcB = 0), signed or unsigned:
  - lo = all ones, hi = srcA unchanged.
  - Sign correction is skipped; the full WIDTH+2 latency still applies.
- Signed overflow (-2^(WIDTH-1) / -1): lo = 0x80000000, hi = 0, the natural result of magnitude division plus negation.
- Multiply by 0 or 1 has no shortcut: latency is fixed regardless of operand values.
- hi/lo hold their values until the next done or reset. srcA/srcB may change freely after acceptance.

Test Plan:
1. Signed mult: start, divide=0, unsignedOp=0, srcA=7, srcB=0xFFFFFFFD.
   Expect: done exactly 34 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for 33 cycles.
2. MULTU: srcA=srcB=0xFFFFFFFF.
   Expect: hi=0xFFFFFFFE, lo=0x00000001. The same operands signed give hi=0, lo=1.
3. Signed div: srcA=0xFFFFFFF9 (-7), srcB=2.
   Expect: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 gives lo=14, hi=2.
4. Divide by zero: srcA=0x64, srcB=0.
   Expect: lo=0xFFFFFFFF, hi=0x00000064.
   Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
5. Hazards:
   - Hold readHiLo=1 from cycle N+5: stall=1 through N+33 and 0 at N+34; the read value is the new lo.
   - Back-to-back start held during busy: second operation accepted in the DONE cycle, its done 34 cycles later.
6. Reset mid-operation: assert reset at N+10 for 1 cycle.
   Expect: next cycle busy=0, stall=0, hi=lo=0, no done. A new start afterwards completes normally.
